// File: rtl/temporizador_dosagem_pkg.sv
// Shared constants for the timed-dispense controller: state codes shown on the
// 7-segment debug display and the FSM state type built on them.
package temporizador_dosagem_pkg;

  localparam logic [2:0] EST_IDLE    = 3'd0;
  localparam logic [2:0] EST_PREPARA = 3'd1;
  localparam logic [2:0] EST_DOSANDO = 3'd2;
  localparam logic [2:0] EST_FIM     = 3'd3;
  localparam logic [2:0] EST_CANCELA = 3'd4;

  typedef enum logic [2:0] {
    ST_IDLE    = EST_IDLE,
    ST_PREPARA = EST_PREPARA,
    ST_DOSANDO = EST_DOSANDO,
    ST_FIM     = EST_FIM,
    ST_CANCELA = EST_CANCELA
  } estado_t;

endpackage

// File: rtl/temporizador_dosagem_if.sv
// Control/status bundle between the operator panel (master) and the
// dispense controller (slave).
interface temporizador_dosagem_if #(parameter int N_UNID = 4);
  logic              iniciar;
  logic              cancelar;
  logic [N_UNID-1:0] tempo;
  logic              valvula;
  logic              pisca;
  logic [N_UNID-1:0] unidades;
  logic              pronto;
  logic              ocupado;
  logic [2:0]        db_estado;

  modport master (
    output iniciar, cancelar, tempo,
    input  valvula, pisca, unidades, pronto, ocupado, db_estado
  );

  modport slave (
    input  iniciar, cancelar, tempo,
    output valvula, pisca, unidades, pronto, ocupado, db_estado
  );
endinterface

// File: rtl/temporizador_dosagem_contador_m.sv
// Modulo-M counter used as a tick prescaler; fim marks the last count while
// counting, so it coincides with the wrap back to zero.
module contador_m #(
  parameter int M = 100,
  parameter int N = 7
) (
  input  logic         clock,
  input  logic         zera_as,
  input  logic         zera_s,
  input  logic         conta,
  output logic [N-1:0] Q,
  output logic         fim,
  output logic         meio
);

  localparam logic [N-1:0] ULTIMO = N'(M - 1);
  localparam logic [N-1:0] METADE = N'((M - 1) / 2);
  localparam logic [N-1:0] UM     = N'(1);

  logic [N-1:0] q_q, q_d;

  always_comb begin
    q_d = q_q;
    if (zera_s)
      q_d = '0;
    else if (conta)
      q_d = (q_q == ULTIMO) ? '0 : q_q + UM;
  end

  always_ff @(posedge clock or posedge zera_as) begin
    if (zera_as) q_q <= '0;
    else         q_q <= q_d;
  end

  assign Q    = q_q;
  assign fim  = conta && (q_q == ULTIMO);
  assign meio = conta && (q_q == METADE);

endmodule

// File: rtl/temporizador_dosagem.sv
// Timed-dispense controller: opens the valve for alvo prescaler units, with
// cancel, a per-unit blink and a one-cycle completion pulse.
module temporizador_dosagem
  import temporizador_dosagem_pkg::*;
#(
  parameter int M_TICK = 50000000,
  parameter int N_TICK = 26,
  parameter int N_UNID = 4
) (
  input  logic                  clock,
  input  logic                  reset,
  temporizador_dosagem_if.slave bus
);

  localparam logic [N_UNID-1:0] UM = N_UNID'(1);

  estado_t           estado_q, estado_d;
  logic [N_UNID-1:0] alvo_q, alvo_d;
  logic [N_UNID-1:0] unidades_q, unidades_d;
  logic              pisca_q, pisca_d;
  logic              tick;
  logic [N_TICK-1:0] presc_q_unused;
  logic              meio_unused;

  contador_m #(.M(M_TICK), .N(N_TICK)) u_presc (
    .clock   (clock),
    .zera_as (reset),
    .zera_s  (estado_q == ST_PREPARA),
    .conta   (estado_q == ST_DOSANDO),
    .Q       (presc_q_unused),
    .fim     (tick),
    .meio    (meio_unused)
  );

  always_comb begin
    estado_d   = estado_q;
    alvo_d     = alvo_q;
    unidades_d = unidades_q;
    pisca_d    = pisca_q;
    case (estado_q)
      ST_IDLE:
        if (bus.iniciar) begin
          alvo_d   = bus.tempo;
          estado_d = (bus.tempo == '0) ? ST_FIM : ST_PREPARA;
        end
      ST_PREPARA: begin
        unidades_d = '0;
        pisca_d    = 1'b0;
        estado_d   = ST_DOSANDO;
      end
      ST_DOSANDO:
        // cancel wins over a same-cycle tick: the partial count stays as it was
        if (bus.cancelar)
          estado_d = ST_CANCELA;
        else if (tick) begin
          unidades_d = unidades_q + UM;
          pisca_d    = ~pisca_q;
          if (unidades_q == alvo_q - UM)
            estado_d = ST_FIM;
        end
      ST_FIM, ST_CANCELA:
        estado_d = ST_IDLE;
      default:
        estado_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      estado_q   <= ST_IDLE;
      alvo_q     <= '0;
      unidades_q <= '0;
      pisca_q    <= 1'b0;
    end else begin
      estado_q   <= estado_d;
      alvo_q     <= alvo_d;
      unidades_q <= unidades_d;
      pisca_q    <= pisca_d;
    end
  end

  assign bus.valvula   = (estado_q == ST_DOSANDO);
  assign bus.pronto    = (estado_q == ST_FIM);
  assign bus.ocupado   = (estado_q != ST_IDLE);
  assign bus.db_estado = estado_q;
  assign bus.unidades  = unidades_q;
  assign bus.pisca     = pisca_q;

endmodule

// File: tb/tb_temporizador_dosagem.sv
// Bench for temporizador_dosagem: timeline model of each dose checked every
// cycle, plus hand-computed literals per directed scenario.
module tb_temporizador_dosagem;

  localparam int M = 5;

  logic clock = 1'b0;
  logic reset = 1'b1;
  always #10 clock = ~clock;

  temporizador_dosagem_if #(.N_UNID(4)) bus();

  temporizador_dosagem #(.M_TICK(M), .N_TICK(3), .N_UNID(4)) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  int n_tests = 0;
  int n_fail  = 0;

  // Dose timeline: m_d = edges since the accepting edge; m_jc = DOSANDO cycle
  // in which cancel was sampled (-1 if none).
  bit m_act  = 1'b0;
  int m_d    = 0;
  int m_alvo = 0;
  int m_jc   = -1;
  int last_u = 0;
  int last_p = 0;
  int v_cnt  = 0;
  int p_cnt  = 0;
  int o_cnt  = 0;

  task automatic check(string name, int act, int exp);
    n_tests++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s at %0t: got %0d expected %0d", name, $time, act, exp);
    end
  endtask

  function automatic int phase_of(int dd);
    if (!m_act) return 0;
    if (m_alvo == 0) return (dd == 0) ? 3 : 0;
    if (m_jc >= 0 && dd == m_jc + 1) return 4;
    if (m_jc >= 0 && dd > m_jc + 1) return 0;
    if (dd == 0) return 1;
    if (dd <= m_alvo * M) return 2;
    if (dd == m_alvo * M + 1) return 3;
    return 0;
  endfunction

  function automatic int units_of(int dd);
    int ph;
    ph = phase_of(dd);
    if (ph == 2) return (dd - 1) / M;
    if (ph == 3 && m_alvo > 0) return m_alvo;
    if (ph == 4) return (m_jc - 1) / M;
    return last_u;
  endfunction

  function automatic int pisca_of(int dd);
    int ph;
    ph = phase_of(dd);
    if (ph == 2) return ((dd - 1) / M) % 2;
    if (ph == 3 && m_alvo > 0) return m_alvo % 2;
    if (ph == 4) return ((m_jc - 1) / M) % 2;
    return last_p;
  endfunction

  always @(posedge clock or posedge reset) begin
    if (reset) begin
      m_act  = 1'b0;
      last_u = 0;
      last_p = 0;
    end else begin
      int ph;
      ph = m_act ? phase_of(m_d) : 0;
      if (ph == 0) begin
        m_act = 1'b0;
        if (bus.iniciar === 1'b1) begin
          m_act  = 1'b1;
          m_d    = 0;
          m_alvo = int'(bus.tempo);
          m_jc   = -1;
        end
      end else if (ph == 3 || ph == 4) begin
        last_u = units_of(m_d);
        last_p = pisca_of(m_d);
        m_act  = 1'b0;
      end else begin
        if (ph == 2 && bus.cancelar === 1'b1) m_jc = m_d;
        m_d++;
      end
    end
  end

  always @(negedge clock) begin
    int st, eu, ep;
    if (reset) begin
      st = 0; eu = 0; ep = 0;
    end else begin
      st = m_act ? phase_of(m_d) : 0;
      eu = m_act ? units_of(m_d) : last_u;
      ep = m_act ? pisca_of(m_d) : last_p;
    end
    check("db_estado", int'(bus.db_estado), st);
    check("valvula",   int'(bus.valvula),   int'(st == 2));
    check("pronto",    int'(bus.pronto),    int'(st == 3));
    check("ocupado",   int'(bus.ocupado),   int'(st != 0));
    check("unidades",  int'(bus.unidades),  eu);
    check("pisca",     int'(bus.pisca),     ep);
    if (bus.valvula === 1'b1) v_cnt++;
    if (bus.pronto  === 1'b1) p_cnt++;
    if (bus.ocupado === 1'b1) o_cnt++;
  end

  task automatic start(int t);
    @(negedge clock);
    bus.tempo   = 4'(t);
    bus.iniciar = 1'b1;
    v_cnt = 0; p_cnt = 0; o_cnt = 0;
    @(negedge clock);
    bus.iniciar = 1'b0;
  endtask

  // leaves the bench at the negedge inside DOSANDO cycle j
  task automatic wait_dos(int j);
    int k;
    k = 0;
    while (bus.valvula !== 1'b1 && k < 50) begin
      @(negedge clock);
      k++;
    end
    check("valvula_rise_timeout", int'(k < 50), 1);
    repeat (j - 1) @(negedge clock);
  endtask

  task automatic wait_idle();
    int k;
    k = 0;
    while (bus.ocupado !== 1'b0 && k < 200) begin
      @(negedge clock);
      k++;
    end
    check("idle_timeout", int'(k < 200), 1);
  endtask

  initial begin
    bus.iniciar  = 1'b0;
    bus.cancelar = 1'b0;
    bus.tempo    = '0;

    // 1: reset, then a reset pulse while idle
    repeat (2) @(negedge clock);
    reset = 1'b0;
    repeat (3) @(negedge clock);
    #3 reset = 1'b1;
    #1;
    check("t1_valvula", int'(bus.valvula), 0);
    check("t1_db", int'(bus.db_estado), 0);
    check("t1_unidades", int'(bus.unidades), 0);
    @(negedge clock);
    reset = 1'b0;

    // 2: tempo=3 full dose
    start(3);
    wait_dos(6);
    check("t2_u_c6", int'(bus.unidades), 1);
    repeat (5) @(negedge clock);
    check("t2_u_c11", int'(bus.unidades), 2);
    wait_idle();
    check("t2_vcnt", v_cnt, 15);
    check("t2_pcnt", p_cnt, 1);
    check("t2_ocnt", o_cnt, 17);
    check("t2_unidades", int'(bus.unidades), 3);
    check("t2_pisca", int'(bus.pisca), 1);

    // 3: tempo=0 completes without opening the valve
    start(0);
    wait_idle();
    check("t3_vcnt", v_cnt, 0);
    check("t3_pcnt", p_cnt, 1);
    check("t3_ocnt", o_cnt, 1);
    check("t3_unidades", int'(bus.unidades), 3);

    // 4: tempo=4, cancel in DOSANDO cycle 7
    start(4);
    wait_dos(7);
    bus.cancelar = 1'b1;
    @(negedge clock);
    bus.cancelar = 1'b0;
    check("t4_db", int'(bus.db_estado), 4);
    check("t4_valvula", int'(bus.valvula), 0);
    wait_idle();
    check("t4_vcnt", v_cnt, 7);
    check("t4_pcnt", p_cnt, 0);
    check("t4_unidades", int'(bus.unidades), 1);

    // 5: start and tempo change during dosing are ignored
    start(2);
    wait_dos(3);
    bus.iniciar = 1'b1;
    bus.tempo   = 4'd9;
    @(negedge clock);
    bus.iniciar = 1'b0;
    wait_idle();
    check("t5_vcnt", v_cnt, 10);
    check("t5_pcnt", p_cnt, 1);
    check("t5_unidades", int'(bus.unidades), 2);

    // 6a: cancel coincident with the final tick
    start(2);
    wait_dos(10);
    bus.cancelar = 1'b1;
    @(negedge clock);
    bus.cancelar = 1'b0;
    check("t6_db", int'(bus.db_estado), 4);
    wait_idle();
    check("t6_pcnt", p_cnt, 0);
    check("t6_vcnt", v_cnt, 10);
    check("t6_unidades", int'(bus.unidades), 1);

    // 6b: asynchronous reset in DOSANDO
    start(2);
    wait_dos(3);
    #5 reset = 1'b1;
    #1;
    check("t6b_valvula", int'(bus.valvula), 0);
    check("t6b_ocupado", int'(bus.ocupado), 0);
    check("t6b_db", int'(bus.db_estado), 0);
    @(negedge clock);
    reset = 1'b0;
    repeat (2) @(negedge clock);
    check("t6b_pcnt", p_cnt, 0);
    check("t6b_unidades", int'(bus.unidades), 0);

    repeat (2) @(negedge clock);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
